apb_requester: RTL
==================

# apb_requester

APB requester (master) that drives the slave side of the APB-to-I2C bridge from a simple command/response interface. It turns one accepted command into one compliant APB transfer (SETUP then ACCESS with wait states) and returns read data and error status. A wait-state timeout guards against addresses where the completer never raises PREADY. It sits between the test/CPU-side command source and the bridge's APB port.

## Interface
- ADDR_W, 32, PADDR / CMD_ADDR width
- DATA_W, 32, PWDATA / PRDATA / command data width
- TIMEOUT, 16, max ACCESS cycles waiting for PREADY; 0 disables the timeout
- PCLK  in  1  single clock, all logic on rising edge
- PRESETn  in  1  reset, synchronous, active-low
- CMD_VALID  in  1  command offered
- CMD_READY  out  1  command accepted when CMD_VALID & CMD_READY at an edge
- CMD_WRITE  in  1  1 = write, 0 = read
- CMD_ADDR  in  ADDR_W  transfer address
- CMD_WDATA  in  DATA_W  write data
- RSP_VALID  out  1  one-cycle completion pulse
- RSP_RDATA  out  DATA_W  captured PRDATA (reads), 0 for writes and timeouts
- RSP_ERROR  out  1  PSLVERR sampled at completion
- RSP_TIMEOUT  out  1  transfer aborted by timeout
- BUSY  out  1  state != IDLE
- PSELx, PENABLE, PWRITE  out  1  APB controls
- PADDR  out  ADDR_W;  PWDATA  out  DATA_W
- PRDATA  in  DATA_W;  PREADY  in  1;  PSLVERR  in  1

## Operation
- FSM states IDLE, SETUP, ACCESS.
- IDLE: CMD_READY=1 (combinational from state). On accept: latch CMD_WRITE/ADDR/WDATA into PWRITE/PADDR/PWDATA, PSELx<=1, PENABLE<=0, go SETUP.
- SETUP: exactly one cycle; PENABLE<=1, clear wait counter, go ACCESS.
- ACCESS, PREADY=1 at edge: complete. PSELx<=0, PENABLE<=0; RSP_VALID<=1; RSP_ERROR<=PSLVERR; RSP_RDATA<=PRDATA if read else 0; RSP_TIMEOUT<=0; go IDLE.
- ACCESS, PREADY=0: increment wait counter. If TIMEOUT!=0 and counter reaches TIMEOUT: abort identically to completion but RSP_TIMEOUT=1, RSP_ERROR=0, RSP_RDATA=0.
- PREADY and timeout on the same edge: PREADY wins (normal completion).
- PADDR, PWDATA, PWRITE stable from SETUP through end of ACCESS; hold last value in IDLE.
- CMD_* ignored outside IDLE; no queuing.
- Commands to any address are issued; address decode is the completer's job.

## Timing
- Reset (PRESETn low at edge): state IDLE; PSELx, PENABLE, PWRITE, RSP_VALID, RSP_ERROR, RSP_TIMEOUT = 0; PADDR, PWDATA, RSP_RDATA = 0; counter 0. Command present during reset is discarded.
- Reset mid-transfer: next edge aborts to reset values, no RSP_VALID.
- Accept edge N: SETUP cycle N..N+1, ACCESS from N+1. Zero wait states: PREADY sampled at N+2, RSP_VALID high N+2..N+3, IDLE (CMD_READY=1) same cycle.
- Minimum command period 3 cycles (IDLE, SETUP, ACCESS); RSP_VALID coincides with the next IDLE cycle.
- Timeout: RSP_VALID rises TIMEOUT+1 cycles after ACCESS entry... precisely after TIMEOUT consecutive PREADY=0 edges in ACCESS.
- Counter width $clog2(TIMEOUT+1), saturating, never wraps.

## Structure
- Package apb_pkg: typedef enum apb_state_t {IDLE, SETUP, ACCESS}; bridge address constants TX_ADDR=0, RX_ADDR=4, CFG_ADDR=8, TMO_ADDR=12.
- One sub-module: apb_wait_timer (clear, enable, expired output, parameter TIMEOUT).

## Test plan
- Write CMD_ADDR=8, CMD_WDATA=0x0000_1234, PREADY at first ACCESS -> PSELx 2 cycles, PENABLE 1 cycle, RSP_VALID 1 cycle, RSP_ERROR=0, RSP_RDATA=0.
- Read CMD_ADDR=4, PRDATA=0xCAFE_BABE, PREADY after 3 wait cycles -> ACCESS lasts 4 cycles, PADDR stable, RSP_RDATA=0xCAFE_BABE.
- Write CMD_ADDR=4 (completer never ready), TIMEOUT=16 -> abort after 16 ACCESS cycles, RSP_TIMEOUT=1, PSELx=0 next cycle.
- Write CMD_ADDR=12 with PSLVERR=1 and PREADY=1 -> RSP_ERROR=1, RSP_TIMEOUT=0.
- PRESETn low during ACCESS -> all outputs 0 next edge, no RSP_VALID; new command accepted after release.
- Back-to-back commands with CMD_VALID held -> accepts every 3 cycles, PENABLE never high in a SETUP cycle.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and bridge register map for the APB requester slice.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam logic [31:0] TX_ADDR  = 32'd0;
    localparam logic [31:0] RX_ADDR  = 32'd4;
    localparam logic [31:0] CFG_ADDR = 32'd8;
    localparam logic [31:0] TMO_ADDR = 32'd12;

endpackage

// File: rtl/apb_requester_if.sv
// APB bus bundle between the requester (master) and the bridge completer (slave).
interface apb_requester_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_wait_timer.sv
// Saturating counter of PREADY=0 edges in ACCESS; flags the edge on which the
// TIMEOUT-th consecutive wait state is being sampled. TIMEOUT=0 never expires.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] count;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + CW'(1);
        end
    end

    // Count holds the number of wait edges already seen, so the current edge is the last allowed one
    assign expired = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/apb_requester.sv
// APB requester: turns one accepted command into one SETUP/ACCESS transfer and
// reports read data, PSLVERR or a wait-state timeout as a one-cycle response.
module apb_requester
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_WDATA,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              RSP_ERROR,
    output logic              RSP_TIMEOUT,
    output logic              BUSY,
    apb_requester_if.master   apb
);
    apb_state_t        state, state_next;
    logic              psel_q, psel_n;
    logic              penable_q, penable_n;
    logic              pwrite_q, pwrite_n;
    logic [ADDR_W-1:0] paddr_q, paddr_n;
    logic [DATA_W-1:0] pwdata_q, pwdata_n;
    logic              rsp_valid_n;
    logic [DATA_W-1:0] rsp_rdata_n;
    logic              rsp_error_n;
    logic              rsp_timeout_n;
    logic              timer_clear;
    logic              timer_enable;
    logic              timer_expired;

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_comb begin
        state_next    = state;
        psel_n        = psel_q;
        penable_n     = penable_q;
        pwrite_n      = pwrite_q;
        paddr_n       = paddr_q;
        pwdata_n      = pwdata_q;
        rsp_valid_n   = 1'b0;
        rsp_rdata_n   = RSP_RDATA;
        rsp_error_n   = RSP_ERROR;
        rsp_timeout_n = RSP_TIMEOUT;
        timer_clear   = 1'b0;
        timer_enable  = 1'b0;
        case (state)
            IDLE: begin
                if (CMD_VALID) begin
                    pwrite_n   = CMD_WRITE;
                    paddr_n    = CMD_ADDR;
                    pwdata_n   = CMD_WDATA;
                    psel_n     = 1'b1;
                    penable_n  = 1'b0;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                penable_n   = 1'b1;
                timer_clear = 1'b1;
                state_next  = ACCESS;
            end
            ACCESS: begin
                // PREADY is checked first so a ready on the expiry edge still completes normally
                if (apb.PREADY) begin
                    psel_n        = 1'b0;
                    penable_n     = 1'b0;
                    rsp_valid_n   = 1'b1;
                    rsp_error_n   = apb.PSLVERR;
                    rsp_rdata_n   = pwrite_q ? '0 : apb.PRDATA;
                    rsp_timeout_n = 1'b0;
                    state_next    = IDLE;
                end else if (timer_expired) begin
                    psel_n        = 1'b0;
                    penable_n     = 1'b0;
                    rsp_valid_n   = 1'b1;
                    rsp_error_n   = 1'b0;
                    rsp_rdata_n   = '0;
                    rsp_timeout_n = 1'b1;
                    state_next    = IDLE;
                end else begin
                    timer_enable = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state       <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            RSP_VALID   <= 1'b0;
            RSP_RDATA   <= '0;
            RSP_ERROR   <= 1'b0;
            RSP_TIMEOUT <= 1'b0;
        end else begin
            state       <= state_next;
            psel_q      <= psel_n;
            penable_q   <= penable_n;
            pwrite_q    <= pwrite_n;
            paddr_q     <= paddr_n;
            pwdata_q    <= pwdata_n;
            RSP_VALID   <= rsp_valid_n;
            RSP_RDATA   <= rsp_rdata_n;
            RSP_ERROR   <= rsp_error_n;
            RSP_TIMEOUT <= rsp_timeout_n;
        end
    end

    assign CMD_READY   = (state == IDLE);
    assign BUSY        = (state != IDLE);
    assign apb.PSELx   = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;

endmodule
